hazard_scoreboard: RTL and testbench

- Pipeline hazard unit for the 5-stage MIPS core. It sits directly downstream of the D-stage control decoder and consumes the decoder's per-instruction Tuse/TnewD/RegWrite/RegDst results.
- It keeps its own shadow pipeline of destination-register and Tnew records for E/M/W. From these it produces the D-stall, the E-bubble insertion and the forwarding-mux selects for the D and E stages.
- All outputs are combinational from registered state plus current D-stage inputs. State advances every clock.

---
 rtl/hazard_scoreboard.sv | 212 +++++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard unit for the 5-stage MIPS core. It keeps a shadow pipeline of
// destination-register / Tnew records for the E, M and W stages and derives
// the D-stage stall, the E-stage bubble and the forwarding-mux selects for
// the D and E stages from them.
//
// Ports:
//   clk        core clock, rising edge
//   reset_n    synchronous active-low reset, clears every record
//   rs_d/rt_d  D-stage source registers
//   tuse_rs_d  cycles until rs is needed, counted from D (3 = unused)
//   tuse_rt_d  same for rt
//   a3_d       D-stage destination register (after RegDst resolution)
//   we_d       D-stage RegWrite
//   tnew_d     D-stage Tnew as seen on E entry
//   stall      hold PC and the D register
//   bubble_e   clear the D/E register this edge (always equals stall)
//   fwd_rs_d   D-stage rs select: 0 regfile, 1 E result, 2 M result
//   fwd_rt_d   D-stage rt select: same encoding
//   fwd_rs_e   E-stage rs select: 0 E-register value, 1 M result, 2 W result
//   fwd_rt_e   E-stage rt select: same encoding
//
// All outputs are combinational from the registered records plus the
// current D-stage inputs; the records advance on every clock edge.
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int TNEW_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rs_d,
    input  logic [ADDR_W-1:0] rt_d,
    input  logic [TNEW_W-1:0] tuse_rs_d,
    input  logic [TNEW_W-1:0] tuse_rt_d,
    input  logic [ADDR_W-1:0] a3_d,
    input  logic              we_d,
    input  logic [TNEW_W-1:0] tnew_d,
    output logic              stall,
    output logic              bubble_e,
    output logic [1:0]        fwd_rs_d,
    output logic [1:0]        fwd_rt_d,
    output logic [1:0]        fwd_rs_e,
    output logic [1:0]        fwd_rt_e
);

    // Tuse value meaning "operand not read".
    localparam logic [TNEW_W-1:0] TUSE_NONE = '1;

    // -----------------------------------------------------------------------
    // Shadow pipeline records
    // -----------------------------------------------------------------------
    logic              e_we;
    logic [ADDR_W-1:0] e_a3;
    logic [TNEW_W-1:0] e_tnew;
    logic [ADDR_W-1:0] e_rs;
    logic [ADDR_W-1:0] e_rt;

    logic              m_we;
    logic [ADDR_W-1:0] m_a3;
    logic [TNEW_W-1:0] m_tnew;

    logic              w_we;
    logic [ADDR_W-1:0] w_a3;
    logic [TNEW_W-1:0] w_tnew;

    // Saturating decrement: a result that is already ready stays ready.
    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
        logic [TNEW_W-1:0] res;
        res = '0;
        if (x != '0) begin
            res = x - 1'b1;
        end
        return res;
    endfunction

    // A stage is a source for r only if it writes r and r is not $0.
    function automatic logic stage_match(
        input logic              we,
        input logic [ADDR_W-1:0] a3,
        input logic [ADDR_W-1:0] r
    );
        return we && (a3 == r) && (r != '0);
    endfunction

    // -----------------------------------------------------------------------
    // Match terms
    // -----------------------------------------------------------------------
    logic e_hit_rs_d, e_hit_rt_d;
    logic m_hit_rs_d, m_hit_rt_d;
    logic m_hit_rs_e, m_hit_rt_e;
    logic w_hit_rs_e, w_hit_rt_e;

    assign e_hit_rs_d = stage_match(e_we, e_a3, rs_d);
    assign e_hit_rt_d = stage_match(e_we, e_a3, rt_d);
    assign m_hit_rs_d = stage_match(m_we, m_a3, rs_d);
    assign m_hit_rt_d = stage_match(m_we, m_a3, rt_d);
    assign m_hit_rs_e = stage_match(m_we, m_a3, e_rs);
    assign m_hit_rt_e = stage_match(m_we, m_a3, e_rt);
    assign w_hit_rs_e = stage_match(w_we, w_a3, e_rs);
    assign w_hit_rt_e = stage_match(w_we, w_a3, e_rt);

    // -----------------------------------------------------------------------
    // Stall: a producer in E or M that needs more cycles than the consumer
    // can wait. W is covered by regfile write-through and never stalls.
    // -----------------------------------------------------------------------
    logic stall_rs;
    logic stall_rt;

    always_comb begin
        stall_rs = 1'b0;
        if (tuse_rs_d != TUSE_NONE) begin
            stall_rs = (e_hit_rs_d && (e_tnew > tuse_rs_d)) ||
                       (m_hit_rs_d && (m_tnew > tuse_rs_d));
        end
    end

    always_comb begin
        stall_rt = 1'b0;
        if (tuse_rt_d != TUSE_NONE) begin
            stall_rt = (e_hit_rt_d && (e_tnew > tuse_rt_d)) ||
                       (m_hit_rt_d && (m_tnew > tuse_rt_d));
        end
    end

    assign stall    = stall_rs || stall_rt;
    assign bubble_e = stall;

    // -----------------------------------------------------------------------
    // Forward selects. The newest matching stage decides; if that stage's
    // result is not ready yet the select falls back to 0 rather than to an
    // older, stale copy (the stall logic covers that case).
    // -----------------------------------------------------------------------
    always_comb begin
        fwd_rs_d = 2'd0;
        if (e_hit_rs_d) begin
            fwd_rs_d = (e_tnew == '0) ? 2'd1 : 2'd0;
        end else if (m_hit_rs_d) begin
            fwd_rs_d = (m_tnew == '0) ? 2'd2 : 2'd0;
        end
    end

    always_comb begin
        fwd_rt_d = 2'd0;
        if (e_hit_rt_d) begin
            fwd_rt_d = (e_tnew == '0) ? 2'd1 : 2'd0;
        end else if (m_hit_rt_d) begin
            fwd_rt_d = (m_tnew == '0) ? 2'd2 : 2'd0;
        end
    end

    always_comb begin
        fwd_rs_e = 2'd0;
        if (m_hit_rs_e) begin
            fwd_rs_e = (m_tnew == '0) ? 2'd1 : 2'd0;
        end else if (w_hit_rs_e) begin
            fwd_rs_e = 2'd2;
        end
    end

    always_comb begin
        fwd_rt_e = 2'd0;
        if (m_hit_rt_e) begin
            fwd_rt_e = (m_tnew == '0) ? 2'd1 : 2'd0;
        end else if (w_hit_rt_e) begin
            fwd_rt_e = 2'd2;
        end
    end

    // -----------------------------------------------------------------------
    // Record advance. A stall injects a bubble into E; M and W always shift.
    // Writes to $0 are recorded with we = 0 so they can never match.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            e_we   <= 1'b0;
            e_a3   <= '0;
            e_tnew <= '0;
            e_rs   <= '0;
            e_rt   <= '0;
            m_we   <= 1'b0;
            m_a3   <= '0;
            m_tnew <= '0;
            w_we   <= 1'b0;
            w_a3   <= '0;
            w_tnew <= '0;
        end else begin
            if (stall) begin
                e_we   <= 1'b0;
                e_a3   <= '0;
                e_tnew <= '0;
                e_rs   <= '0;
                e_rt   <= '0;
            end else begin
                e_we   <= we_d && (a3_d != '0);
                e_a3   <= a3_d;
                e_tnew <= tnew_d;
                e_rs   <= rs_d;
                e_rt   <= rt_d;
            end
            m_we   <= e_we;
            m_a3   <= e_a3;
            m_tnew <= sat_dec(e_tnew);
            w_we   <= m_we;
            w_a3   <= m_a3;
            w_tnew <= sat_dec(m_tnew);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// The reference model tracks issued instructions by age since entering E
// (0 = E, 1 = M, 2 = W) and derives remaining latency as max(tnew - age, 0).
// The driver pushes the predicted output vector per cycle into exp_q; a
// monitor on the falling edge pops and compares. Directed scenarios add
// constant checks on top of the model.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;

    logic       clk;
    logic       reset_n;
    logic [4:0] rs_d, rt_d, a3_d;
    logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d;
    logic       we_d;
    logic       stall, bubble_e;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

    hazard_scoreboard #(.ADDR_W(5), .TNEW_W(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rs_d     (rs_d),
        .rt_d     (rt_d),
        .tuse_rs_d(tuse_rs_d),
        .tuse_rt_d(tuse_rt_d),
        .a3_d     (a3_d),
        .we_d     (we_d),
        .tnew_d   (tnew_d),
        .stall    (stall),
        .bubble_e (bubble_e),
        .fwd_rs_d (fwd_rs_d),
        .fwd_rt_d (fwd_rt_d),
        .fwd_rs_e (fwd_rs_e),
        .fwd_rt_e (fwd_rt_e)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic       we;
        logic [4:0] a3;
        int         tnew;
        logic [4:0] rs;
        logic [4:0] rt;
        int         age;
    } ent_t;

    ent_t pipe_q[$];

    // {rdy_rt, rdy_rs, stall, bubble, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e}
    logic [11:0] exp_q[$];

    function automatic int rem(ent_t e);
        return (e.tnew > e.age) ? e.tnew - e.age : 0;
    endfunction

    function automatic bit writes(ent_t e, logic [4:0] r);
        return e.we && e.a3 == r && r != 0;
    endfunction

    function automatic bit m_stall(logic [4:0] r, int tuse);
        bit s = 0;
        if (tuse == 3) return 0;
        foreach (pipe_q[i])
            if (pipe_q[i].age <= 1 && writes(pipe_q[i], r) && rem(pipe_q[i]) > tuse) s = 1;
        return s;
    endfunction

    // newest producer among ages [lo..hi]; returns index or -1
    function automatic int newest(logic [4:0] r, int lo, int hi);
        int best = -1;
        foreach (pipe_q[i])
            if (pipe_q[i].age >= lo && pipe_q[i].age <= hi && writes(pipe_q[i], r))
                if (best < 0 || pipe_q[i].age < pipe_q[best].age) best = i;
        return best;
    endfunction

    function automatic logic [1:0] m_fwd_d(logic [4:0] r);
        int k = newest(r, 0, 1);
        if (k < 0 || rem(pipe_q[k]) != 0) return 2'd0;
        return (pipe_q[k].age == 0) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [1:0] m_fwd_e(bit use_rt);
        logic [4:0] r = 0;
        int k;
        foreach (pipe_q[i])
            if (pipe_q[i].age == 0) r = use_rt ? pipe_q[i].rt : pipe_q[i].rs;
        k = newest(r, 1, 2);
        if (k < 0) return 2'd0;
        if (pipe_q[k].age == 2) return 2'd2;
        return (rem(pipe_q[k]) == 0) ? 2'd1 : 2'd0;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input bit rst_n, input logic [4:0] rs, input int tu_rs,
                         input logic [4:0] rt, input int tu_rt,
                         input logic [4:0] a3, input bit we, input int tn,
                         input bit predict);
        bit s;
        bit rdy_rs, rdy_rt;
        ent_t n;
        @(posedge clk);
        #1;
        reset_n   = rst_n;
        rs_d      = rs;
        rt_d      = rt;
        tuse_rs_d = 2'(tu_rs);
        tuse_rt_d = 2'(tu_rt);
        a3_d      = a3;
        we_d      = we;
        tnew_d    = 2'(tn);
        s = m_stall(rs, tu_rs) || m_stall(rt, tu_rt);
        // operand needed in D right now and a producer is in flight
        rdy_rs = (tu_rs == 0) && (newest(rs, 0, 1) >= 0);
        rdy_rt = (tu_rt == 0) && (newest(rt, 0, 1) >= 0);
        if (predict)
            exp_q.push_back({rdy_rt, rdy_rs, s, s, m_fwd_d(rs), m_fwd_d(rt),
                             m_fwd_e(0), m_fwd_e(1)});
        // state after the coming edge
        if (!rst_n) begin
            pipe_q.delete();
        end else begin
            foreach (pipe_q[i]) pipe_q[i].age++;
            for (int i = pipe_q.size() - 1; i >= 0; i--)
                if (pipe_q[i].age > 2) pipe_q.delete(i);
            if (!s) begin
                n.we = we && a3 != 0; n.a3 = a3; n.tnew = tn;
                n.rs = rs; n.rt = rt; n.age = 0;
                pipe_q.push_back(n);
            end
        end
    endtask

    task automatic nop();
        drive(1, 0, 3, 0, 3, 0, 0, 0, 1);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [11:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("stall",    int'(stall),    int'(e[9]));
            check("bubble_e", int'(bubble_e), int'(e[8]));
            check("fwd_rs_d", int'(fwd_rs_d), int'(e[7:6]));
            check("fwd_rt_d", int'(fwd_rt_d), int'(e[5:4]));
            check("fwd_rs_e", int'(fwd_rs_e), int'(e[3:2]));
            check("fwd_rt_e", int'(fwd_rt_e), int'(e[1:0]));
            // a producer in flight that is not forwardable must stall
            if (e[10] && !stall) check("ready_prop_rs", int'(fwd_rs_d != 0), 1);
            if (e[11] && !stall) check("ready_prop_rt", int'(fwd_rt_d != 0), 1);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int budget;
        reset_n = 0; rs_d = 0; rt_d = 0; tuse_rs_d = 3; tuse_rt_d = 3;
        a3_d = 0; we_d = 0; tnew_d = 0;
        // first reset cycle: records are unknown until this edge
        drive(0, 8, 0, 8, 0, 8, 1, 2, 0);
        drive(0, 8, 0, 8, 0, 8, 1, 2, 1);
        #1;
        check("reset_stall", int'(stall), 0);
        check("reset_fwd", int'({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e}), 0);

        // lw $8 ; addu $9,$8,$10 -> one stall, then W forward in E
        drive(1, 0, 3, 0, 3, 8, 1, 2, 1);
        drive(1, 8, 1, 10, 1, 9, 1, 1, 1); #1 check("lw_addu_stall", int'(stall), 1);
        drive(1, 8, 1, 10, 1, 9, 1, 1, 1); #1 check("lw_addu_release", int'(stall), 0);
        nop();                              #1 check("lw_addu_fwd_rs_e", int'(fwd_rs_e), 2);
        nop(); nop(); nop();

        // lw $8 ; beq $8,$0 -> two stalls, then regfile
        drive(1, 0, 3, 0, 3, 8, 1, 2, 1);
        drive(1, 8, 0, 0, 0, 0, 0, 0, 1);   #1 check("lw_beq_stall1", int'(stall), 1);
        drive(1, 8, 0, 0, 0, 0, 0, 0, 1);   #1 check("lw_beq_stall2", int'(stall), 1);
        drive(1, 8, 0, 0, 0, 0, 0, 0, 1);   #1 check("lw_beq_release", int'(stall), 0);
        check("lw_beq_fwd_rs_d", int'(fwd_rs_d), 0);
        nop(); nop(); nop();

        // addu $5 ; beq $5,$5 -> one stall, then M forward on both
        drive(1, 1, 1, 2, 1, 5, 1, 1, 1);
        drive(1, 5, 0, 5, 0, 0, 0, 0, 1);   #1 check("addu_beq_stall", int'(stall), 1);
        drive(1, 5, 0, 5, 0, 0, 0, 0, 1);   #1 check("addu_beq_release", int'(stall), 0);
        check("addu_beq_fwd_rs_d", int'(fwd_rs_d), 2);
        check("addu_beq_fwd_rt_d", int'(fwd_rt_d), 2);
        nop(); nop(); nop();

        // jal ; jr $31 -> no stall, E forward
        drive(1, 0, 3, 0, 3, 31, 1, 0, 1);
        drive(1, 31, 0, 0, 3, 0, 0, 0, 1);  #1 check("jal_jr_stall", int'(stall), 0);
        check("jal_jr_fwd_rs_d", int'(fwd_rs_d), 1);
        nop(); nop(); nop();

        // write $0 then read $0; unused operand on a live register
        drive(1, 0, 3, 0, 3, 0, 1, 2, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);   #1 check("r0_stall", int'(stall), 0);
        check("r0_fwd", int'({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e}), 0);
        drive(1, 0, 3, 0, 3, 7, 1, 2, 1);
        drive(1, 7, 3, 7, 3, 0, 0, 0, 1);   #1 check("tuse3_stall", int'(stall), 0);
        nop(); nop(); nop();

        // reset during a load-use stall
        drive(1, 0, 3, 0, 3, 8, 1, 2, 1);
        drive(1, 8, 1, 0, 3, 9, 1, 1, 1);   #1 check("rst_pre_stall", int'(stall), 1);
        drive(0, 8, 1, 0, 3, 9, 1, 1, 1);
        drive(1, 8, 1, 0, 3, 9, 1, 1, 1);   #1 check("rst_post_stall", int'(stall), 0);
        check("rst_post_fwd_rs_d", int'(fwd_rs_d), 0);
        nop();                              #1 check("rst_post_fwd_rs_e", int'(fwd_rs_e), 0);

        // randomized traffic on a small register window
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 49) != 0),
                  5'($urandom_range(0, 7)), $urandom_range(0, 3),
                  5'($urandom_range(0, 7)), $urandom_range(0, 3),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2), 1);
        end

        budget = 100;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
